pass_sequencer: RTL and testbench

- Datapath-side counterpart of the training-pass controller FSM.
- Consumes the controller's one-hot pass levels (f0, f1, backward) and walks the weight-memory address space for the selected pass.
- Issues one address per beat to the MAC datapath over a valid/ready handshake.
- Returns the completion signals the controller waits on: a f0_end pulse and an end_check level.
- Sits between the controller FSM and the weight SRAM/MAC unit.

---
 rtl/pass_sequencer.sv | 176 +++++++++++++++++
 tb/tb_pass_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pass_sequencer.sv
// rtl/pass_sequencer.sv - walks weight-memory addresses for the selected training pass
// Emits one beat per accepted valid/ready handshake and reports completion to the pass controller.
module pass_sequencer #(
    parameter int N_IN  = 4,
    parameter int N_HID = 4,
    parameter int N_OUT = 2,
    parameter int AW    = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          f0_pass_i,
    input  logic          f1_pass_i,
    input  logic          b_pass_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [AW-1:0] addr_o,
    output logic [2:0]    row_o,
    output logic [2:0]    col_o,
    output logic [1:0]    pass_o,
    output logic          f0_end_o,
    output logic          end_check_o,
    output logic          busy_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [1:0]    P_NONE  = 2'b00;
    localparam logic [1:0]    P_F0    = 2'b01;
    localparam logic [1:0]    P_F1    = 2'b10;
    localparam logic [1:0]    P_B     = 2'b11;
    localparam logic [2:0]    IN_LAST  = 3'(N_IN - 1);
    localparam logic [2:0]    HID_LAST = 3'(N_HID - 1);
    localparam logic [2:0]    OUT_LAST = 3'(N_OUT - 1);
    localparam logic [AW-1:0] F1_BASE  = AW'(N_IN * N_HID);
    localparam logic [AW-1:0] B_BASE   = AW'(N_IN * N_HID + N_HID * N_OUT - 1);

    state_t          state_q, state_d;
    logic [1:0]      pass_q, pass_d;
    logic [2:0]      row_q, row_d;
    logic [2:0]      col_q, col_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            f0_end_q, f0_end_d;
    logic            end_check_q, end_check_d;

    logic            req_held;
    logic            col_last;
    logic            last_beat;

    // The pass that was latched must stay requested, otherwise the run aborts or DONE releases.
    always_comb begin
        req_held  = 1'b0;
        col_last  = 1'b0;
        last_beat = 1'b0;
        case (pass_q)
            P_F0: begin
                req_held  = f0_pass_i;
                col_last  = (col_q == IN_LAST);
                last_beat = (row_q == HID_LAST) && (col_q == IN_LAST);
            end
            P_F1: begin
                req_held  = f1_pass_i;
                col_last  = (col_q == HID_LAST);
                last_beat = (row_q == OUT_LAST) && (col_q == HID_LAST);
            end
            P_B: begin
                req_held  = b_pass_i;
                last_beat = (row_q == 3'd0) && (col_q == 3'd0);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        row_d       = row_q;
        col_d       = col_q;
        addr_d      = addr_q;
        f0_end_d    = f0_end_q;
        end_check_d = end_check_q;
        if (en_i) begin
            f0_end_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (f0_pass_i) begin
                        state_d = RUN;
                        pass_d  = P_F0;
                        row_d   = 3'd0;
                        col_d   = 3'd0;
                        addr_d  = '0;
                    end else if (f1_pass_i) begin
                        state_d = RUN;
                        pass_d  = P_F1;
                        row_d   = 3'd0;
                        col_d   = 3'd0;
                        addr_d  = F1_BASE;
                    end else if (b_pass_i) begin
                        state_d = RUN;
                        pass_d  = P_B;
                        row_d   = OUT_LAST;
                        col_d   = HID_LAST;
                        addr_d  = B_BASE;
                    end
                end
                RUN: begin
                    // Completion beats an abort requested in the same cycle.
                    if (ready_i && last_beat) begin
                        state_d     = DONE;
                        f0_end_d    = (pass_q == P_F0);
                        end_check_d = 1'b1;
                    end else if (!req_held) begin
                        state_d = IDLE;
                        pass_d  = P_NONE;
                    end else if (ready_i) begin
                        if (pass_q == P_B) begin
                            if (col_q == 3'd0) begin
                                col_d = HID_LAST;
                                row_d = row_q - 3'd1;
                            end else begin
                                col_d = col_q - 3'd1;
                            end
                            addr_d = addr_q - AW'(1);
                        end else begin
                            if (col_last) begin
                                col_d = 3'd0;
                                row_d = row_q + 3'd1;
                            end else begin
                                col_d = col_q + 3'd1;
                            end
                            addr_d = addr_q + AW'(1);
                        end
                    end
                end
                DONE: begin
                    if (!req_held) begin
                        state_d     = IDLE;
                        pass_d      = P_NONE;
                        end_check_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            pass_q      <= P_NONE;
            row_q       <= 3'd0;
            col_q       <= 3'd0;
            addr_q      <= '0;
            f0_end_q    <= 1'b0;
            end_check_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pass_q      <= pass_d;
            row_q       <= row_d;
            col_q       <= col_d;
            addr_q      <= addr_d;
            f0_end_q    <= f0_end_d;
            end_check_q <= end_check_d;
        end
    end

    assign valid_o     = (state_q == RUN);
    assign busy_o      = (state_q != IDLE);
    assign addr_o      = addr_q;
    assign row_o       = row_q;
    assign col_o       = col_q;
    assign pass_o      = pass_q;
    assign f0_end_o    = f0_end_q;
    assign end_check_o = end_check_q;

endmodule

// File: tb/tb_pass_sequencer.sv
// tb/tb_pass_sequencer.sv - directed and randomized checks of pass_sequencer against a beat-list model
module tb_pass_sequencer;
    localparam int N_IN  = 4;
    localparam int N_HID = 4;
    localparam int N_OUT = 2;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b1;
    logic          f0 = 1'b0, f1 = 1'b0, bp = 1'b0;
    logic          ready = 1'b0;
    logic          valid;
    logic [AW-1:0] addr;
    logic [2:0]    row, col;
    logic [1:0]    pass;
    logic          f0_end, end_check, busy;

    int errors = 0;
    int checks = 0;

    pass_sequencer #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .AW(AW)) dut (
        .clk_i(clk), .rst_i(rst_n), .en_i(en),
        .f0_pass_i(f0), .f1_pass_i(f1), .b_pass_i(bp), .ready_i(ready),
        .valid_o(valid), .addr_o(addr), .row_o(row), .col_o(col), .pass_o(pass),
        .f0_end_o(f0_end), .end_check_o(end_check), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic [2:0] r);
        f0 = r[0];
        f1 = r[1];
        bp = r[2];
    endtask

    // Beat k of a pass as a flat index into that layer's weight matrix.
    task automatic exp_beat(input int p, input int k, output int ea, output int er, output int ec);
        int j;
        if (p == 1) begin
            ea = k; er = k / N_IN; ec = k % N_IN;
        end else if (p == 2) begin
            ea = N_IN * N_HID + k; er = k / N_HID; ec = k % N_HID;
        end else begin
            j  = N_HID * N_OUT - 1 - k;
            ea = N_IN * N_HID + j; er = j / N_HID; ec = j % N_HID;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_f0end"}, f0_end, 0);
        check({tag, "_endchk"}, end_check, 0);
    endtask

    // mode: 0 ready always high, 1 alternating 1/0, 2 random
    task automatic do_pass(input int p, input logic [2:0] req, input int mode,
                           input int stall_at, input bit drop_last);
        int total, k, cyc, ea, er, ec;
        bit stalled, tgl;
        total = (p == 1) ? N_IN * N_HID : N_HID * N_OUT;
        k = 0; cyc = 0; stalled = 0; tgl = 1;
        @(negedge clk);
        drive_req(req);
        ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        while (k < total && cyc < 300) begin
            cyc++;
            exp_beat(p, k, ea, er, ec);
            check("valid", valid, 1);
            check("addr", addr, ea);
            check("row", row, er);
            check("col", col, ec);
            check("pass", pass, p);
            check("f0end_run", f0_end, 0);
            check("endchk_run", end_check, 0);
            if (stall_at == k && !stalled) begin
                stalled = 1;
                en = 1'b0;
                ready = 1'b1;
                repeat (3) begin
                    @(posedge clk);
                    @(negedge clk);
                    check("stall_addr", addr, ea);
                    check("stall_valid", valid, 1);
                end
                en = 1'b1;
            end
            case (mode)
                0: ready = 1'b1;
                1: begin ready = tgl; tgl = !tgl; end
                default: ready = 1'($urandom_range(0, 1));
            endcase
            if (drop_last && k == total - 1 && ready) drive_req(3'b000);
            @(posedge clk);
            if (ready) k++;
            @(negedge clk);
        end
        check("beats_done", k, total);
        ready = 1'b0;
        check("done_valid", valid, 0);
        check("done_f0end", f0_end, (p == 1) ? 1 : 0);
        check("done_endchk", end_check, 1);
        check("done_busy", busy, 1);
        check("done_pass", pass, p);
        if (drop_last) begin
            @(posedge clk);
            @(negedge clk);
            check_idle("droplast_exit");
        end else begin
            @(posedge clk);
            @(negedge clk);
            check("hold_f0end", f0_end, 0);
            check("hold_endchk", end_check, 1);
            check("hold_valid", valid, 0);
            drive_req(3'b000);
            @(posedge clk);
            @(negedge clk);
            check_idle("release");
        end
    endtask

    initial begin
        int ea, er, ec;
        #2;
        check_idle("reset");
        check("reset_addr", addr, 0);
        check("reset_row", row, 0);
        check("reset_col", col, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_pass(1, 3'b001, 0, -1, 0);
        do_pass(2, 3'b010, 1, -1, 0);
        do_pass(3, 3'b100, 0, -1, 0);
        do_pass(1, 3'b101, 0, -1, 0);

        // abort f0 after 5 beats
        @(negedge clk);
        drive_req(3'b001);
        ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("abort_pre_addr", addr, 5);
        drive_req(3'b000);
        @(posedge clk);
        @(negedge clk);
        check_idle("abort");
        @(posedge clk);
        @(negedge clk);
        check("abort_no_pulse", f0_end, 0);
        ready = 1'b0;
        do_pass(2, 3'b010, 0, -1, 0);

        do_pass(1, 3'b001, 0, 6, 0);
        do_pass(2, 3'b010, 0, 7, 1);
        do_pass(1, 3'b001, 1, -1, 1);
        for (int i = 0; i < 3; i++) begin
            do_pass(1, 3'b001, 2, -1, 0);
            do_pass(2, 3'b010, 2, int'($urandom_range(0, 7)), 0);
            do_pass(3, 3'b100, 2, -1, 0);
        end

        // asynchronous reset in the middle of a b run
        @(negedge clk);
        drive_req(3'b100);
        ready = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        exp_beat(3, 3, ea, er, ec);
        check("prereset_addr", addr, ea);
        rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        check("async_reset_addr", addr, 0);
        check("async_reset_row", row, 0);
        check("async_reset_col", col, 0);
        @(negedge clk);
        drive_req(3'b000);
        ready = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
